// File: rtl/cpu_pkg.sv
// Shared CPU-wide types and defaults used by the fetch path.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int CODE_WORDS_DEF = 16;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'd0;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t inst;
    } fetch_entry_t;

    function automatic int addr_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, inst} between the code memory and decode.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o,
    output logic         empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          full;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    // A pop frees the slot in the same cycle, so a full queue can still accept.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential reads to a 1-cycle synchronous code
// memory, buffers responses in fetch_queue, and handles redirects.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              CODE_WORDS  = CODE_WORDS_DEF,
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEF,
    parameter int              QUEUE_DEPTH = 2,
    localparam int             AW          = addr_w(CODE_WORDS)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_en,
    output logic [AW-1:0]   imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    word_t         fpc_q, fpc_d;
    word_t         inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic [CW-1:0] q_count;
    logic          q_empty;
    logic          pop, push, issue;
    logic [CW:0]   occupancy;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign pop = inst_valid && inst_ready;
    // Slots already committed once this cycle's pop and the in-flight response settle.
    assign occupancy = {1'b0, q_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue     = !reset && !redirect_valid && (occupancy < (CW+1)'(QUEUE_DEPTH));
    // A redirect kills the response of the request issued last cycle.
    assign push      = inflight_q && !redirect_valid;

    assign push_entry.pc   = inflight_pc_q;
    assign push_entry.inst = imem_rdata;

    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fpc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue) begin
            fpc_d         = fpc_q + 32'd4;
            inflight_pc_d = fpc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (q_count),
        .empty_o    (q_empty)
    );

    assign imem_en    = issue;
    assign imem_addr  = fpc_q[AW+1:2];
    assign inst_valid = !reset && !q_empty;
    assign inst       = inst_valid ? head.inst : '0;
    assign inst_pc    = inst_valid ? head.pc : '0;

endmodule
